// File: rtl/lram_arb_pkg.sv
// Shared types for the local-RAM port arbiter: FSM states and the ram_sel owner encoding.
package lram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_GPU  = 2'd1,
        SEL_MTX  = 2'd2,
        SEL_EXT  = 2'd3
    } sel_t;

endpackage

// File: rtl/lram_fair_cnt.sv
// Saturating counter of internal grants made while an external request waits.
module lram_fair_cnt #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q;

    assign at_limit = (cnt_q == LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !at_limit) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/lram_arb.sv
// Local RAM port arbiter: mtx > gpu > ext with atomic lock on external grants.
// Define LRAM_ARB_FAIR_EN to force an ext grant after FAIR_LIMIT internal grants.
module lram_arb
    import lram_arb_pkg::*;
#(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned FAIR_W     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       gpu_mreq,
    input  logic       mtx_mreq,
    input  logic       mtx_atomic,
    input  logic       ext_req,
    input  logic       ram_rdy,
    output logic       ram_cs,
    output logic [1:0] ram_sel,
    output logic       gpu_ack,
    output logic       mtx_ack,
    output logic       ext_ack,
    output logic       ext_wait,
    output logic       busy
);

    state_t state_q, state_d;
    sel_t   owner_q, owner_d;
    sel_t   pick;
    logic   ext_elig;
    logic   fair_force;

    assign ext_elig = ext_req & ~mtx_atomic;

`ifdef LRAM_ARB_FAIR_EN
    logic fair_inc;
    logic fair_clr;

    // Count only internal grants that actually overtook an eligible external request.
    assign fair_inc = (state_q == IDLE) && ext_elig &&
                      ((pick == SEL_MTX) || (pick == SEL_GPU));
    assign fair_clr = ~ext_req || ((state_q == IDLE) && (pick == SEL_EXT));

    lram_fair_cnt #(
        .LIMIT (FAIR_LIMIT),
        .W     (FAIR_W)
    ) u_fair_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (fair_inc),
        .clr      (fair_clr),
        .at_limit (fair_force)
    );
`else
    assign fair_force = 1'b0;
`endif

    always_comb begin
        pick = SEL_NONE;
        if (ext_elig && fair_force) begin
            pick = SEL_EXT;
        end else if (mtx_mreq) begin
            pick = SEL_MTX;
        end else if (gpu_mreq) begin
            pick = SEL_GPU;
        end else if (ext_elig) begin
            pick = SEL_EXT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= SEL_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (pick != SEL_NONE) begin
                    state_d = ACCESS;
                    owner_d = pick;
                end
            end
            ACCESS: begin
                if (ram_rdy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                owner_d = SEL_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = SEL_NONE;
            end
        endcase
    end

    // Owner is kept through DONE so the ack can be decoded from registers alone.
    assign ram_cs   = (state_q == ACCESS);
    assign busy     = ram_cs;
    assign ram_sel  = ram_cs ? owner_q : SEL_NONE;
    assign gpu_ack  = (state_q == DONE) && (owner_q == SEL_GPU);
    assign mtx_ack  = (state_q == DONE) && (owner_q == SEL_MTX);
    assign ext_ack  = (state_q == DONE) && (owner_q == SEL_EXT);
    assign ext_wait = ext_req & ~(ram_cs && (owner_q == SEL_EXT)) & ~ext_ack;

endmodule

// File: tb/tb_lram_arb.sv
// Directed self-checking bench for lram_arb (strict or LRAM_ARB_FAIR_EN build).
module tb_lram_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       gpu_mreq, mtx_mreq, mtx_atomic, ext_req, ram_rdy;
    logic       ram_cs, gpu_ack, mtx_ack, ext_ack, ext_wait, busy;
    logic [1:0] ram_sel;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    lram_arb #(
        .FAIR_LIMIT (4),
        .FAIR_W     (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gpu_mreq   (gpu_mreq),
        .mtx_mreq   (mtx_mreq),
        .mtx_atomic (mtx_atomic),
        .ext_req    (ext_req),
        .ram_rdy    (ram_rdy),
        .ram_cs     (ram_cs),
        .ram_sel    (ram_sel),
        .gpu_ack    (gpu_ack),
        .mtx_ack    (mtx_ack),
        .ext_ack    (ext_ack),
        .ext_wait   (ext_wait),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic cs, input logic [1:0] sel,
                           input logic [2:0] acks);
        chk({tag, ".cs"},   {3'b0, ram_cs}, {3'b0, cs});
        chk({tag, ".sel"},  {2'b0, ram_sel}, {2'b0, sel});
        chk({tag, ".acks"}, {1'b0, gpu_ack, mtx_ack, ext_ack}, {1'b0, acks});
    endtask

    logic [1:0] exp_sel;

    initial begin
        // Reset with every request high
        reset_n = 1'b0; gpu_mreq = 1'b1; mtx_mreq = 1'b1; ext_req = 1'b1;
        mtx_atomic = 1'b0; ram_rdy = 1'b1;
        tick(); tick();
        chk_out("rst", 1'b0, 2'd0, 3'b000);
        chk("rst.busy", {3'b0, busy}, 4'd0);
        reset_n = 1'b1;
        tick();
        chk_out("rel.grant", 1'b1, 2'd2, 3'b000);
        chk("rel.busy", {3'b0, busy}, 4'd1);
        tick();
        chk_out("rel.done", 1'b0, 2'd0, 3'b010);
        chk("rel.busy_done", {3'b0, busy}, 4'd0);
        mtx_mreq = 1'b0; gpu_mreq = 1'b0; ext_req = 1'b0;
        tick();
        chk_out("rel.idle", 1'b0, 2'd0, 3'b000);

        // Wait states: ram_rdy low for three ACCESS cycles
        ram_rdy = 1'b0; gpu_mreq = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("ws.acc%0d", i), 1'b1, 2'd1, 3'b000);
            if (i == 3) ram_rdy = 1'b1;
            tick();
        end
        chk_out("ws.done", 1'b0, 2'd0, 3'b100);
        gpu_mreq = 1'b0;
        tick();
        chk_out("ws.idle", 1'b0, 2'd0, 3'b000);

        // Atomic lock blocks ext
        mtx_atomic = 1'b1; ext_req = 1'b1; mtx_mreq = 1'b1;
        #1;
        chk("lock.wait0", {3'b0, ext_wait}, 4'd1);
        tick();
        chk_out("lock.mtx", 1'b1, 2'd2, 3'b000);
        chk("lock.wait1", {3'b0, ext_wait}, 4'd1);
        tick();
        chk_out("lock.mdone", 1'b0, 2'd0, 3'b010);
        mtx_mreq = 1'b0;
        tick();
        chk_out("lock.idle", 1'b0, 2'd0, 3'b000);
        chk("lock.wait2", {3'b0, ext_wait}, 4'd1);
        tick();
        chk_out("lock.held", 1'b0, 2'd0, 3'b000);
        chk("lock.wait3", {3'b0, ext_wait}, 4'd1);
        mtx_atomic = 1'b0; ram_rdy = 1'b0;
        tick();
        chk_out("lock.ext", 1'b1, 2'd3, 3'b000);
        chk("lock.wait4", {3'b0, ext_wait}, 4'd0);

        // Atomic rises during the ext access
        mtx_atomic = 1'b1;
        tick();
        chk_out("amid.acc", 1'b1, 2'd3, 3'b000);
        ram_rdy = 1'b1;
        tick();
        chk_out("amid.done", 1'b0, 2'd0, 3'b001);
        chk("amid.wait", {3'b0, ext_wait}, 4'd0);
        ext_req = 1'b0; mtx_atomic = 1'b0;
        tick();
        chk_out("amid.idle", 1'b0, 2'd0, 3'b000);

        // Fairness: gpu held high with ext waiting
        gpu_mreq = 1'b1; ext_req = 1'b1; ram_rdy = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
`ifdef LRAM_ARB_FAIR_EN
            exp_sel = (g == 4) ? 2'd3 : 2'd1;
`else
            exp_sel = 2'd1;
`endif
            chk_out($sformatf("fair.grant%0d", g), 1'b1, exp_sel, 3'b000);
            tick();
            chk_out($sformatf("fair.done%0d", g), 1'b0, 2'd0,
                    (exp_sel == 2'd3) ? 3'b001 : 3'b100);
            tick();
        end
        gpu_mreq = 1'b0; ext_req = 1'b0;
        #1;
        chk("fair.idle_busy", {3'b0, busy}, 4'd0);
        tick();

        // Reset in the second ACCESS cycle of a gpu access
        gpu_mreq = 1'b1; ram_rdy = 1'b0;
        tick();
        chk_out("rmid.acc1", 1'b1, 2'd1, 3'b000);
        tick();
        chk_out("rmid.acc2", 1'b1, 2'd1, 3'b000);
        reset_n = 1'b0;
        #1;
        chk_out("rmid.rst", 1'b0, 2'd0, 3'b000);
        chk("rmid.busy", {3'b0, busy}, 4'd0);
        gpu_mreq = 1'b0; ram_rdy = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("rmid.post%0d", k), 1'b0, 2'd0, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
